md_unit: RTL and testbench

- Multiply/divide unit with HI/LO registers.
- Sits in the execute stage directly downstream of the general register file: it consumes the two GPR read ports as src_a/src_b.
- Models fixed MIPS multi-cycle latency and exposes busy so hazard logic can stall later MULT/DIV/MFHI/MFLO/MTHI/MTLO.
- HI/LO feed the MFHI/MFLO path back towards GPR write-back.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e      : operation encodings carried on md_op
//   MULT_CYCLES_DEF / DIV_CYCLES_DEF : default operation latencies
//   CNT_W        : width of the latency counter
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and fixed multi-cycle latency.
// Ports:
//   clk    : clock, all state changes on rising edge
//   reset  : synchronous, active-high
//   start  : one-cycle request, accepted only when busy is low
//   md_op  : operation (md_pkg::md_op_e encoding)
//   src_a  : rs operand (multiplicand / dividend / MTHI-MTLO data)
//   src_b  : rt operand (multiplier / divisor)
//   busy   : registered, high while a MULT/DIV is in flight
//   hi, lo : HI/LO registers
// The result is computed at accept and parked in a pending register; the
// counter releases it into HI/LO at the completion edge.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;

    md_op_e op;
    assign op = md_op_e'(md_op);

    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;
    logic               div_ovf;
    logic               b_zero;

    always_comb begin
        a_s    = src_a;
        b_s    = src_b;
        prod_s = 64'(a_s) * 64'(b_s);
        prod_u = {32'd0, src_a} * {32'd0, src_b};
        b_zero = (src_b == '0);
        // Most-negative / -1 overflows 32-bit signed division; pin the
        // architectural result instead of relying on the operator.
        div_ovf = (src_a == 32'h8000_0000) && (src_b == '1);
        quot_s  = '0;
        rem_s   = '0;
        quot_u  = '0;
        rem_u   = '0;
        if (!b_zero) begin
            quot_u = src_a / src_b;
            rem_u  = src_a % src_b;
            if (div_ovf) begin
                quot_s = 32'sh8000_0000;
                rem_s  = '0;
            end else begin
                quot_s = a_s / b_s;
                rem_s  = a_s % b_s;
            end
        end
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d    = 1'b0;
                pend_wr_d = 1'b0;
                if (pend_wr_q) begin
                    hi_d = pend_q[63:32];
                    lo_d = pend_q[31:0];
                end
            end
        end else if (start) begin
            unique case (op)
                MD_MTHI: hi_d = src_a;
                MD_MTLO: lo_d = src_a;
                MD_MULT, MD_MULTU: begin
                    pend_d    = (op == MD_MULT) ? prod_s : prod_u;
                    pend_wr_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    pend_d    = (op == MD_DIV) ? {rem_s, quot_s} : {rem_u, quot_u};
                    pend_wr_d = !b_zero;
                    busy_d    = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver predicts the post-edge
// {busy, hi, lo} from an arithmetic reference model keyed on absolute edge
// numbers; a monitor on the falling edge pops and compares.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy;
    logic [31:0] hi, lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0;
    longint      m_done_edge = 0;
    logic        m_wr = 1'b0;
    logic [63:0] m_res = '0;
    longint      edge_no = 0;

    function automatic logic [63:0] model_result(input logic [2:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        int      ia, ib;
        longint  sa, sb, q, r;
        longint unsigned ua, ub;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return 64'(ua * ub);
            3'd3: begin
                q = sa / sb;  // 64-bit arithmetic: -2^31 / -1 is exact here
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: return {32'(ua % ub), 32'(ua / ub)};
            default: return '0;
        endcase
    endfunction

    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst; start = st; md_op = op; src_a = a; src_b = b;
        edge_no++;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_wr = 1'b0;
        end else if (m_busy) begin
            if (edge_no == m_done_edge) begin
                m_busy = 1'b0;
                if (m_wr) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                end
            end
        end else if (st) begin
            case (op)
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                3'd1, 3'd2: begin
                    m_busy = 1'b1; m_wr = 1'b1;
                    m_done_edge = edge_no + 5;
                    m_res = model_result(op, a, b);
                end
                3'd3, 3'd4: begin
                    m_busy = 1'b1; m_wr = (b != 0);
                    m_done_edge = edge_no + 10;
                    if (b != 0) m_res = model_result(op, a, b);
                end
                default: ;
            endcase
        end
        e.busy = m_busy; e.hi = m_hi; e.lo = m_lo; e.tag = tag;
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 3'd0, $urandom, $urandom, tag);
    endtask

    // Monitor: one expectation per edge, checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (busy !== e.busy) begin
                n_err++;
                $display("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
            end
            n_cmp++;
            if (hi !== e.hi) begin
                n_err++;
                $display("FAIL %s hi: got %h expected %h", e.tag, hi, e.hi);
            end
            n_cmp++;
            if (lo !== e.lo) begin
                n_err++;
                $display("FAIL %s lo: got %h expected %h", e.tag, lo, e.lo);
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
        step(1'b1, 1'b0, 3'd0, 0, 0, "reset");
        step(1'b1, 1'b1, 3'd6, 32'hFFFF, 0, "reset_dominates");
        idle(3, "reset_idle");

        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        idle(6, "mult_neg");
        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
        idle(6, "multu");

        step(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        idle(11, "div_neg");
        step(1'b0, 1'b1, 3'd4, 32'd7, 32'd2, "divu");
        idle(11, "divu");
        step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        idle(11, "div_ovf");

        step(1'b0, 1'b1, 3'd5, 32'h1234_5678, 0, "mthi");
        step(1'b0, 1'b1, 3'd6, 32'h9ABC_DEF0, 0, "mtlo");
        step(1'b0, 1'b1, 3'd3, 32'd55, 32'd0, "div0");
        idle(11, "div0");

        step(1'b0, 1'b1, 3'd1, 32'd3, 32'd4, "mult_busy");
        step(1'b0, 1'b1, 3'd6, 32'hDEAD, 32'd1, "mtlo_ignored");
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7, "div_ignored");
        step(1'b0, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "src_change");
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, "src_change");
        step(1'b0, 1'b1, 3'd5, 32'hBEEF, 0, "start_at_done");
        idle(2, "mult_busy_done");

        step(1'b0, 1'b1, 3'd4, 32'd1000, 32'd3, "div_abort");
        idle(3, "div_abort");
        step(1'b1, 1'b0, 3'd0, 0, 0, "div_abort_rst");
        idle(12, "no_late_write");

        for (int i = 0; i < 400; i++) begin
            logic rst_r;
            rst_r = ($urandom_range(0, 63) == 0);
            step(rst_r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 rand_operand(), rand_operand(), "random");
        end
        idle(12, "drain");

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
